// File: rtl/mem_lsu_if.sv
// Data-memory bus of the load/store stage: master = LSU, slave = data memory.
// Handshake: mem_req/mem_addr/mem_we/mem_wdata/mem_wmask are held stable until the
// cycle mem_gnt is seen high with mem_req; the load reply is one mem_rvalid pulse.
interface mem_lsu_if #(
  parameter int DW = 64
);
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage: one instruction in flight, single-outstanding memory access,
// load alignment/extension. Optional misalignment trap: define MEM_MISALIGN_CHECK_EN.
module mem_lsu #(
  parameter int DW = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          inst_load,
  input  logic          inst_store,
  input  logic [1:0]    mem_size,
  input  logic          load_unsigned,
  input  logic [DW-1:0] alu_raw_res,
  input  logic [DW-1:0] rs2_data,
  input  logic [DW-1:0] ex_odata,
  input  logic [RW-1:0] rd_addr,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_rd_addr,
  output logic          misalign_exc,
  mem_lsu_if.master     mem,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic          ld_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [2:0]    off_q;
  logic [RW-1:0] rd_q;

  logic          misal;
  logic [7:0]    lane_mask;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_ext;

  assign state_dbg = state;
  assign ex_ready  = (state == IDLE) && !rst;

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misal = 1'b0;
    case (mem_size)
      2'd1:    misal = alu_raw_res[0];
      2'd2:    misal = |alu_raw_res[1:0];
      2'd3:    misal = |alu_raw_res[2:0];
      default: misal = 1'b0;
    endcase
    if (!(inst_load || inst_store)) misal = 1'b0;
  end
`else
  assign misal = 1'b0;
`endif

  // Lanes past byte 7 fall off the 8-bit mask and the DW-bit data shift.
  always_comb begin
    lane_mask = 8'h00;
    case (mem_size)
      2'd0:    lane_mask = 8'h01 << alu_raw_res[2:0];
      2'd1:    lane_mask = 8'h03 << alu_raw_res[2:0];
      2'd2:    lane_mask = 8'h0F << alu_raw_res[2:0];
      default: lane_mask = 8'hFF << alu_raw_res[2:0];
    endcase
  end

  always_comb begin
    shifted  = mem.mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {{(DW-8){1'b0}}, shifted[7:0]}
                             : {{(DW-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = uns_q ? {{(DW-16){1'b0}}, shifted[15:0]}
                             : {{(DW-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {{(DW-32){1'b0}}, shifted[31:0]}
                             : {{(DW-32){shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ld_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= 3'd0;
      rd_q          <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd_addr    <= '0;
      misalign_exc  <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wmask <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            ld_q   <= inst_load;
            uns_q  <= load_unsigned;
            size_q <= mem_size;
            off_q  <= alu_raw_res[2:0];
            rd_q   <= rd_addr;
            if (misal) begin
              state        <= DONE;
              wb_valid     <= 1'b1;
              wb_data      <= alu_raw_res;
              wb_rd_addr   <= '0;
              misalign_exc <= 1'b1;
            end else if (inst_load || inst_store) begin
              state         <= REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= !inst_load;
              mem.mem_addr  <= {alu_raw_res[DW-1:3], 3'b000};
              mem.mem_wdata <= inst_load ? '0 : (rs2_data << {alu_raw_res[2:0], 3'b000});
              mem.mem_wmask <= inst_load ? 8'h00 : lane_mask;
            end else begin
              state      <= DONE;
              wb_valid   <= 1'b1;
              wb_data    <= ex_odata;
              wb_rd_addr <= rd_addr;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wmask <= 8'h00;
            if (ld_q) begin
              state <= WAIT;
            end else begin
              state      <= DONE;
              wb_valid   <= 1'b1;
              wb_data    <= '0;
              wb_rd_addr <= '0;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            state      <= DONE;
            wb_valid   <= 1'b1;
            wb_data    <= load_ext;
            wb_rd_addr <= rd_q;
          end
        end
        default: begin
          if (wb_ready) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd_addr   <= '0;
            misalign_exc <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage, directly downstream of the execute stage. It takes one EX result per transaction: effective address `alu_raw_res`, store data `rs2_data`, non-memory result `ex_odata`. It runs a single-outstanding load/store handshake to data memory, aligns and sign- or zero-extends load data, and hands a single write-back packet to the WB stage. The stage is not pipelined: one instruction is in flight at a time, under a valid/ready handshake on both sides.

## Interface
Parameters:
- `DW`, 64: data and address width (RV64).
- `RW`, 5: register-index width.

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `ex_valid`  in  1  EX presents an instruction.
- `ex_ready`  out  1  stage accepts; high only in IDLE and while `rst`=0.
- `inst_load`  in  1  instruction is a load. Load wins if `inst_store` is also set.
- `inst_store`  in  1  instruction is a store.
- `mem_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- `load_unsigned`  in  1  zero-extend the load (LBU/LHU/LWU).
- `alu_raw_res`  in  DW  effective address.
- `rs2_data`  in  DW  store data (low bytes significant).
- `ex_odata`  in  DW  result for non-memory instructions.
- `rd_addr`  in  RW  destination register.
- `wb_valid`  out  1  write-back packet valid.
- `wb_ready`  in  1  WB consumes the packet.
- `wb_data`  out  DW  result to write back.
- `wb_rd_addr`  out  RW  destination register; 0 for stores and exceptions.
- `misalign_exc`  out  1  misaligned access flag, qualified by `wb_valid`.
- `mem_req`  out  1  memory request.
- `mem_gnt`  in  1  memory accepts the request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  DW  doubleword-aligned address (`addr[2:0]`=0).
- `mem_wdata`  out  DW  store data shifted into byte lanes.
- `mem_wmask`  out  8  byte-lane write enables.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  DW  load data, full doubleword.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - `ex_ready`=1.
  - On `ex_valid`: capture all inputs into internal registers.
  - If the instruction is a load or store, go to REQ; otherwise go to DONE with `wb_data`=`ex_odata`.
- REQ:
  - `mem_req`=1, with `mem_addr`/`mem_we`/`mem_wdata`/`mem_wmask` driven from the registers and held stable until `mem_gnt`.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT.
  - `mem_rvalid` in REQ is ignored.
- WAIT:
  - On `mem_rvalid`: select bytes starting at lane `addr[2:0]`, extend per `mem_size`/`load_unsigned`, register into `wb_data`, go to DONE.
- DONE:
  - `wb_valid`=1, with outputs held stable.
  - On `wb_ready`: go to IDLE.
- Store lanes:
  - `mem_wmask` = ({1,3,15,255} for sizes 0..3) << `addr[2:0]`, truncated to 8 bits.
  - `mem_wdata` = `rs2_data` << (8×`addr[2:0]`).
  - Bytes shifted past lane 7 are dropped.
- Load extension: byte, half and word loads are sign-extended from bit 7/15/31 unless `load_unsigned`. A double load is passed through unchanged.
- Stores write back nothing: `wb_rd_addr`=0, `wb_data`=0.
- `mem_rvalid` outside WAIT is ignored (e.g. a stale response after reset).

## Timing
- Reset values:
  - `ex_ready` 0 during reset, 1 from the first cycle after reset.
  - All other outputs 0.
  - State is IDLE.
- Reset mid-operation aborts the transaction. `mem_req` and `wb_valid` are 0 on the cycle after the reset edge.
- Latencies, counted from the accept edge N:
  - Non-memory: `wb_valid` at N+1.
  - Store with immediate grant: `mem_req` at N+1, `wb_valid` at N+2.
  - Load with grant at N+1 and `mem_rvalid` at N+2: `wb_valid` at N+3.
- No overlap: `ex_ready`=0 from N+1 until the cycle after the `wb_valid`&`wb_ready` handshake.
- Throughput: at most one instruction per 2 cycles.
- `wb_valid`, once asserted, stays asserted with stable data until `wb_ready`. The same holds for `mem_req` until `mem_gnt`.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - At capture, an access is misaligned if `addr` is not a multiple of its size (half: `addr[0]`; word: `addr[1:0]`; double: `addr[2:0]`).
  - A misaligned access goes IDLE→DONE directly with no `mem_req`, and presents `misalign_exc`=1, `wb_rd_addr`=0, `wb_data`=`addr`.
- `MEM_MISALIGN_CHECK_EN` undefined: `misalign_exc` is tied 0, and the truncated-lane behaviour described under Operation applies.

## Test plan
- Non-memory instruction: `ex_odata`=0x1234, `rd_addr`=5, `wb_ready`=1 → `wb_valid` one cycle after accept with `wb_data`=0x1234, `wb_rd_addr`=5, and `mem_req` never asserted.
- Signed byte load: addr 0x1003, `mem_rdata`=0x00000000_80000000 shifted so lane 3 holds 0x80 → `mem_addr`=0x1000, `wb_data`=0xFFFFFFFFFFFFFF80. The same access with `load_unsigned`=1 → `wb_data`=0x80.
- Word store: addr 0x2004, `rs2_data`=0xAABBCCDD, `mem_gnt` delayed 3 cycles → `mem_req` held 4 cycles with `mem_wmask`=0xF0, `mem_wdata`=0xAABBCCDD_00000000; `wb_valid` one cycle after grant with `wb_rd_addr`=0.
- Backpressure: `wb_ready` held low 5 cycles → `wb_valid` and `wb_data` stable, `ex_ready`=0 throughout; the next instruction is accepted only after the handshake.
- Reset while in WAIT, then a stray `mem_rvalid` in IDLE → no `wb_valid`, state stays IDLE, `ex_ready`=1.
- With `MEM_MISALIGN_CHECK_EN`: half load at 0x3001 → no `mem_req`, `wb_valid` at N+1 with `misalign_exc`=1, `wb_data`=0x3001.
